// File: rtl/icache_pkg.sv
// Shared state encoding, AXI read-burst constants and line layout for the
// direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MISS_REQ = 3'd2,
    REFILL   = 3'd3,
    RESPOND  = 3'd4
  } state_t;

  localparam int LINE_BYTES  = 64;
  localparam int BEATS       = 8;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int TAG_MAX_W   = 64 - OFFSET_BITS;

  localparam logic [7:0] AR_LEN   = 8'd7;
  localparam logic [2:0] AR_SIZE  = 3'd3;
  localparam logic [1:0] AR_BURST = 2'b01;
  localparam logic [2:0] AR_PROT  = 3'b100;

  // Tag is sized for the smallest index; unused upper bits stay zero.
  typedef struct packed {
    logic                   valid;
    logic [TAG_MAX_W-1:0]   tag;
    logic [BEATS-1:0][63:0] data;
  } line_t;

  function automatic logic [31:0] select_word(input logic [63:0] beat, input logic upper);
    return upper ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/icache_tag_data_array.sv
// Flop-based line storage: combinational read, one line write port and a
// single-cycle global invalidate of all valid bits.
module icache_tag_data_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             invalidate,
  input  logic [IDX_W-1:0] rd_index,
  output line_t            rd_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  line_t            wr_line
);

  logic [NUM_SETS-1:0]    valid_r;
  logic [TAG_MAX_W-1:0]   tag_r  [NUM_SETS];
  logic [BEATS-1:0][63:0] data_r [NUM_SETS];

  // Valid bits; invalidate wins over an install in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= '0;
    end else if (invalidate) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_index] <= wr_line.valid;
    end
  end

  // Tag and data payload; meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_index]  <= wr_line.tag;
      data_r[wr_index] <= wr_line.data;
    end
  end

  assign rd_line.valid = valid_r[rd_index];
  assign rd_line.tag   = tag_r[rd_index];
  assign rd_line.data  = data_r[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache; misses refill a 64-byte line
// with one 8-beat INCR burst on the AXI read channels.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_SETS   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [63:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_error,
  input  logic                  flush,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int IDX_W = $clog2(NUM_SETS);

  state_t                 state_r;
  logic [63:0]            addr_r;
  logic [2:0]             beat_cnt_r;
  logic [BEATS-1:0][63:0] buf_r;
  logic                   err_r;
  logic                   flushed_r;
  logic                   req_ready_r;
  logic                   resp_valid_r;
  logic [31:0]            resp_data_r;
  logic                   resp_error_r;
  logic                   arvalid_r;
  logic                   rready_r;
  logic [ADDR_WIDTH-1:0]  araddr_r;

  logic [IDX_W-1:0]       index_s;
  logic [TAG_MAX_W-1:0]   tag_s;
  line_t                  rd_line_s;
  line_t                  wr_line_s;
  logic                   hit_s;
  logic                   misaligned_s;
  logic                   beat_err_s;
  logic                   last_beat_s;
  logic                   wr_en_s;
  logic [BEATS-1:0][63:0] fill_data_s;
  logic                   unused_s;

  assign index_s      = addr_r[OFFSET_BITS +: IDX_W];
  assign tag_s        = TAG_MAX_W'(addr_r >> (OFFSET_BITS + IDX_W));
  assign hit_s        = rd_line_s.valid && (rd_line_s.tag == tag_s);
  assign misaligned_s = (addr_r[1:0] != 2'b00);
  assign beat_err_s   = (m_axi_rresp != 2'b00);
  assign last_beat_s  = (state_r == REFILL) && m_axi_rvalid && (beat_cnt_r == 3'd7);
  // The final beat is still on the bus, so the line is assembled around it.
  assign fill_data_s  = {m_axi_rdata[63:0], buf_r[BEATS-2:0]};
  assign wr_en_s      = last_beat_s && !err_r && !beat_err_s && !flushed_r && !flush;

  assign wr_line_s.valid = 1'b1;
  assign wr_line_s.tag   = tag_s;
  assign wr_line_s.data  = fill_data_s;

  icache_tag_data_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .invalidate (flush),
    .rd_index   (index_s),
    .rd_line    (rd_line_s),
    .wr_en      (wr_en_s),
    .wr_index   (index_s),
    .wr_line    (wr_line_s)
  );

  // Request/refill/response sequencer with registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      addr_r       <= 64'd0;
      beat_cnt_r   <= 3'd0;
      buf_r        <= '0;
      err_r        <= 1'b0;
      flushed_r    <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'd0;
      resp_error_r <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      araddr_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r      <= req_addr;
            req_ready_r <= 1'b0;
            state_r     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (misaligned_s) begin
            resp_data_r  <= 32'd0;
            resp_error_r <= 1'b1;
            resp_valid_r <= 1'b1;
            state_r      <= RESPOND;
          end else if (hit_s && !flush) begin
            resp_data_r  <= select_word(rd_line_s.data[addr_r[5:3]], addr_r[2]);
            resp_error_r <= 1'b0;
            resp_valid_r <= 1'b1;
            state_r      <= RESPOND;
          end else begin
            araddr_r   <= ADDR_WIDTH'({addr_r[63:OFFSET_BITS], {OFFSET_BITS{1'b0}}});
            arvalid_r  <= 1'b1;
            beat_cnt_r <= 3'd0;
            err_r      <= 1'b0;
            flushed_r  <= 1'b0;
            state_r    <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (flush) begin
            flushed_r <= 1'b1;
          end
          if (m_axi_arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= REFILL;
          end
        end
        REFILL: begin
          if (flush) begin
            flushed_r <= 1'b1;
          end
          if (m_axi_rvalid) begin
            buf_r[beat_cnt_r] <= m_axi_rdata[63:0];
            beat_cnt_r        <= beat_cnt_r + 3'd1;
            if (beat_err_s) begin
              err_r <= 1'b1;
            end
            // Beat count, not rlast, ends the burst.
            if (beat_cnt_r == 3'd7) begin
              rready_r     <= 1'b0;
              resp_valid_r <= 1'b1;
              resp_error_r <= err_r | beat_err_s;
              resp_data_r  <= select_word(fill_data_s[addr_r[5:3]], addr_r[2]);
              state_r      <= RESPOND;
            end
          end
        end
        RESPOND: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          arvalid_r    <= 1'b0;
          rready_r     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_r;
  assign resp_valid    = resp_valid_r;
  assign resp_data     = resp_data_r;
  assign resp_error    = resp_error_r;
  assign m_axi_arid    = {ID_WIDTH{1'b0}};
  assign m_axi_araddr  = araddr_r;
  assign m_axi_arlen   = AR_LEN;
  assign m_axi_arsize  = AR_SIZE;
  assign m_axi_arburst = AR_BURST;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0000;
  assign m_axi_arprot  = AR_PROT;
  assign m_axi_arvalid = arvalid_r;
  assign m_axi_rready  = rready_r;

  assign unused_s = ^{m_axi_rid, m_axi_rlast};

endmodule
